// File: rtl/ram_dual_port_be_if.sv
// ram_dual_port_be_if: write/read port bundle for ram_dual_port_be.
// Ports (master drives, slave receives):
//   data, write_addr, we, be  - write port with per-byte lane enables
//   read_addr, re             - read port
//   q, q_valid, busy          - read data, read-valid flag, clear-sweep busy
interface ram_dual_port_be_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned BYTE_W     = 8
);
    localparam int unsigned LANES = DATA_WIDTH / BYTE_W;

    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic                  we;
    logic [LANES-1:0]      be;
    logic [ADDR_WIDTH-1:0] read_addr;
    logic                  re;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_valid;
    logic                  busy;

    modport master (
        output data, write_addr, we, be, read_addr, re,
        input  q, q_valid, busy
    );

    modport slave (
        input  data, write_addr, we, be, read_addr, re,
        output q, q_valid, busy
    );
endinterface

// File: rtl/ram_dual_port_be.sv
// ram_dual_port_be: simple dual-port RAM (one write, one read port, one clock)
// with per-byte write enables, selectable read-during-write behaviour, optional
// output register and a post-reset sweep that fills the array with CLEAR_VALUE.
// Ports:
//   clk    - clock, all logic on posedge
//   rst_n  - synchronous active-low reset
//   bus    - slave side of ram_dual_port_be_if (write/read ports, q, q_valid, busy)
module ram_dual_port_be #(
    parameter int unsigned            DATA_WIDTH     = 32,
    parameter int unsigned            ADDR_WIDTH     = 6,
    parameter int unsigned            BYTE_W         = 8,
    parameter bit                     RDW_MODE       = 1'b0,
    parameter bit                     OUT_REG        = 1'b0,
    parameter bit                     CLEAR_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0]  CLEAR_VALUE    = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_dual_port_be_if.slave  bus
);
    localparam int unsigned LANES = DATA_WIDTH / BYTE_W;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] cnt_next;
    logic                  clear_we_c;

    logic                  port_ok_c;
    logic                  wr_fire_c;
    logic                  rd_fire_c;
    logic [DATA_WIDTH-1:0] rd_old_c;
    logic [DATA_WIDTH-1:0] merged_c;
    logic [DATA_WIDTH-1:0] rd_word_c;

    logic                  rd_valid_s1;
    logic [DATA_WIDTH-1:0] rd_data_s1;

    // Sweep state register; reset restarts the sweep at address 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RESET_STATE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Sweep next-state: one word per cycle, leave CLEAR after the last address.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clear_we_c = 1'b0;
        case (state)
            IDLE: begin
                state_next = IDLE;
            end
            CLEAR: begin
                clear_we_c = 1'b1;
                cnt_next   = cnt + ADDR_WIDTH'(1);
                if (cnt == '1) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // busy is the decoded state flop, so it has no input-to-output path.
    assign bus.busy = (state == CLEAR);

    // Port accesses only count outside reset and outside the sweep.
    assign port_ok_c = rst_n && (state == IDLE);
    assign wr_fire_c = port_ok_c && bus.we;
    assign rd_fire_c = port_ok_c && bus.re;

    // Read word selection; the merged word models a same-edge write landing first.
    always_comb begin
        rd_old_c = mem[bus.read_addr];
        merged_c = rd_old_c;
        for (int i = 0; i < int'(LANES); i++) begin
            if (bus.be[i]) begin
                merged_c[i*BYTE_W +: BYTE_W] = bus.data[i*BYTE_W +: BYTE_W];
            end
        end
        rd_word_c = rd_old_c;
        if (RDW_MODE && bus.we && (bus.write_addr == bus.read_addr)) begin
            rd_word_c = merged_c;
        end
    end

    // Array write: sweep has priority (ports are blocked while it runs anyway).
    always_ff @(posedge clk) begin
        if (rst_n && clear_we_c) begin
            mem[cnt] <= CLEAR_VALUE;
        end else if (wr_fire_c) begin
            for (int i = 0; i < int'(LANES); i++) begin
                if (bus.be[i]) begin
                    mem[bus.write_addr][i*BYTE_W +: BYTE_W] <= bus.data[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // First read stage; data holds when no read is issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid_s1 <= 1'b0;
            rd_data_s1  <= '0;
        end else begin
            rd_valid_s1 <= rd_fire_c;
            if (rd_fire_c) begin
                rd_data_s1 <= rd_word_c;
            end
        end
    end

    // Optional output register adds one cycle of latency at full throughput.
    generate
        if (OUT_REG) begin : g_out_reg
            logic                  rd_valid_s2;
            logic [DATA_WIDTH-1:0] rd_data_s2;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_valid_s2 <= 1'b0;
                    rd_data_s2  <= '0;
                end else begin
                    rd_valid_s2 <= rd_valid_s1;
                    if (rd_valid_s1) begin
                        rd_data_s2 <= rd_data_s1;
                    end
                end
            end

            assign bus.q       = rd_data_s2;
            assign bus.q_valid = rd_valid_s2;
        end else begin : g_no_out_reg
            assign bus.q       = rd_data_s1;
            assign bus.q_valid = rd_valid_s1;
        end
    endgenerate
endmodule

// File: tb/tb_ram_dual_port_be.sv
// tb_ram_dual_port_be: directed, table-driven bench for ram_dual_port_be.
// dut_a: RDW old-data, latency 1, clear sweep.
// dut_b: RDW new-data, latency 2, clear sweep (same stimulus as dut_a).
// dut_c: no clear sweep, latency 2, own stimulus.
module tb_ram_dual_port_be;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned BW = 8;
    localparam logic [31:0] CV = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_dual_port_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_W(BW)) bus_a ();
    ram_dual_port_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_W(BW)) bus_b ();
    ram_dual_port_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_W(BW)) bus_c ();

    ram_dual_port_be #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_W(BW), .RDW_MODE(1'b0),
        .OUT_REG(1'b0), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

    ram_dual_port_be #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_W(BW), .RDW_MODE(1'b1),
        .OUT_REG(1'b1), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    ram_dual_port_be #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_W(BW), .RDW_MODE(1'b0),
        .OUT_REG(1'b1), .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(CV)
    ) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] d;
        logic [3:0]  be;
        logic        re;
        logic [3:0]  ra;
        logic        ev;   // read issued this row
        logic [31:0] qa;   // word expected from dut_a (old-data RDW)
        logic [31:0] qb;   // word expected from dut_b (new-data RDW)
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ab(input logic we, input logic [3:0] wa, input logic [31:0] d,
                            input logic [3:0] be, input logic re, input logic [3:0] ra);
        bus_a.we = we; bus_a.write_addr = wa; bus_a.data = d; bus_a.be = be;
        bus_a.re = re; bus_a.read_addr = ra;
        bus_b.we = we; bus_b.write_addr = wa; bus_b.data = d; bus_b.be = be;
        bus_b.re = re; bus_b.read_addr = ra;
    endtask

    task automatic drive_c(input logic we, input logic [3:0] wa, input logic [31:0] d,
                           input logic [3:0] be, input logic re, input logic [3:0] ra);
        bus_c.we = we; bus_c.write_addr = wa; bus_c.data = d; bus_c.be = be;
        bus_c.re = re; bus_c.read_addr = ra;
    endtask

    function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [31:0] d,
                                input logic [3:0] be, input logic re, input logic [3:0] ra,
                                input logic [31:0] qa, input logic [31:0] qb);
        vec_t v;
        v.we = we; v.wa = wa; v.d = d; v.be = be;
        v.re = re; v.ra = ra; v.ev = re; v.qa = qa; v.qb = qb;
        return v;
    endfunction

    // Counts posedges until dut_a drops busy; reads held meanwhile must stay invalid.
    task automatic sweep_cycles(output int cycles);
        cycles = 0;
        for (int k = 0; k < 40 && bus_a.busy; k++) begin
            tick();
            cycles++;
            check("sweep_qvalid_a", 32'(bus_a.q_valid), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          cycles;
        logic [31:0] last_qa;
        logic [31:0] last_qb;
        logic        prev_ev;
        logic [31:0] prev_qb;

        tbl[0]  = mk(1'b1, 4'd3, 32'h11223344, 4'b1111, 1'b0, 4'd0, 32'h0, 32'h0);
        tbl[1]  = mk(1'b1, 4'd3, 32'hAABBCCDD, 4'b0101, 1'b0, 4'd0, 32'h0, 32'h0);
        tbl[2]  = mk(1'b0, 4'd0, 32'h0,        4'b0000, 1'b1, 4'd3, 32'h11BB33DD, 32'h11BB33DD);
        tbl[3]  = mk(1'b1, 4'd5, 32'h0,        4'b1111, 1'b0, 4'd0, 32'h0, 32'h0);
        tbl[4]  = mk(1'b1, 4'd5, 32'hFFFFFFFF, 4'b0011, 1'b1, 4'd5, 32'h00000000, 32'h0000FFFF);
        tbl[5]  = mk(1'b0, 4'd0, 32'h0,        4'b0000, 1'b1, 4'd5, 32'h0000FFFF, 32'h0000FFFF);
        tbl[6]  = mk(1'b1, 4'd0, 32'd0,        4'b1111, 1'b0, 4'd0, 32'h0, 32'h0);
        tbl[7]  = mk(1'b1, 4'd1, 32'd1,        4'b1111, 1'b0, 4'd0, 32'h0, 32'h0);
        tbl[8]  = mk(1'b1, 4'd2, 32'd2,        4'b1111, 1'b0, 4'd0, 32'h0, 32'h0);
        tbl[9]  = mk(1'b1, 4'd3, 32'd3,        4'b1111, 1'b0, 4'd0, 32'h0, 32'h0);
        tbl[10] = mk(1'b1, 4'd6, 32'h12345678, 4'b0000, 1'b1, 4'd0, 32'd0, 32'd0);
        tbl[11] = mk(1'b1, 4'd7, 32'h00000077, 4'b1111, 1'b1, 4'd1, 32'd1, 32'd1);
        tbl[12] = mk(1'b0, 4'd0, 32'h0,        4'b0000, 1'b1, 4'd2, 32'd2, 32'd2);
        tbl[13] = mk(1'b0, 4'd0, 32'h0,        4'b0000, 1'b1, 4'd3, 32'd3, 32'd3);
        tbl[14] = mk(1'b0, 4'd0, 32'h0,        4'b0000, 1'b0, 4'd0, 32'h0, 32'h0);
        tbl[15] = mk(1'b0, 4'd0, 32'h0,        4'b0000, 1'b1, 4'd6, CV, CV);
        tbl[16] = mk(1'b0, 4'd0, 32'h0,        4'b0000, 1'b1, 4'd7, 32'h77, 32'h77);
        tbl[17] = mk(1'b0, 4'd0, 32'h0,        4'b0000, 1'b0, 4'd0, 32'h0, 32'h0);

        // Reset held for two cycles.
        rst_n = 1'b0;
        drive_ab(1'b0, 4'd0, 32'h0, 4'b0, 1'b0, 4'd0);
        drive_c(1'b0, 4'd0, 32'h0, 4'b0, 1'b0, 4'd0);
        tick();
        tick();
        check("rst_busy_a",   32'(bus_a.busy),    32'd1);
        check("rst_busy_b",   32'(bus_b.busy),    32'd1);
        check("rst_q_a",      bus_a.q,            32'h0);
        check("rst_qvalid_a", 32'(bus_a.q_valid), 32'd0);
        check("rst_q_b",      bus_b.q,            32'h0);
        check("rst_qvalid_b", 32'(bus_b.q_valid), 32'd0);
        check("rst_busy_c",   32'(bus_c.busy),    32'd0);

        // Clear sweep with a read of addr 15 held throughout.
        rst_n = 1'b1;
        drive_ab(1'b0, 4'd0, 32'h0, 4'b0, 1'b1, 4'd15);
        sweep_cycles(cycles);
        check("sweep_busy_cycles", 32'(cycles),       32'd16);
        check("sweep_busy_b",      32'(bus_b.busy),   32'd0);
        check("sweep_qvalid_b",    32'(bus_b.q_valid), 32'd0);
        tick();
        check("first_read_q_a",      bus_a.q,             CV);
        check("first_read_qvalid_a", 32'(bus_a.q_valid),  32'd1);
        check("first_read_qvalid_b", 32'(bus_b.q_valid),  32'd0);
        drive_ab(1'b0, 4'd0, 32'h0, 4'b0, 1'b0, 4'd0);
        tick();
        check("hold_qvalid_a",       32'(bus_a.q_valid),  32'd0);
        check("hold_q_a",            bus_a.q,             CV);
        check("first_read_q_b",      bus_b.q,             CV);
        check("first_read_qvalid_b2",32'(bus_b.q_valid),  32'd1);

        // Table: dut_a checked on the same row, dut_b one row later.
        last_qa = CV;
        last_qb = CV;
        prev_ev = 1'b0;
        prev_qb = 32'h0;
        for (int i = 0; i < NV; i++) begin
            drive_ab(tbl[i].we, tbl[i].wa, tbl[i].d, tbl[i].be, tbl[i].re, tbl[i].ra);
            tick();
            if (tbl[i].ev) last_qa = tbl[i].qa;
            if (prev_ev) last_qb = prev_qb;
            check($sformatf("vec%0d_qvalid_a", i), 32'(bus_a.q_valid), 32'(tbl[i].ev));
            check($sformatf("vec%0d_q_a", i),      bus_a.q,            last_qa);
            check($sformatf("vec%0d_qvalid_b", i), 32'(bus_b.q_valid), 32'(prev_ev));
            check($sformatf("vec%0d_q_b", i),      bus_b.q,            last_qb);
            prev_ev = tbl[i].ev;
            prev_qb = tbl[i].qb;
        end

        // Reset mid-sweep, with writes pressed against the busy window.
        rst_n = 1'b0;
        drive_ab(1'b0, 4'd0, 32'h0, 4'b0, 1'b0, 4'd0);
        tick();
        check("rst2_q_a",      bus_a.q,            32'h0);
        check("rst2_qvalid_a", 32'(bus_a.q_valid), 32'd0);
        check("rst2_busy_c",   32'(bus_c.busy),    32'd0);
        rst_n = 1'b1;
        drive_ab(1'b1, 4'd2, 32'h12345678, 4'b1111, 1'b0, 4'd0);
        repeat (7) tick();
        check("mid_sweep_busy_a", 32'(bus_a.busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sweep_cycles(cycles);
        check("resweep_busy_cycles", 32'(cycles), 32'd16);
        drive_ab(1'b0, 4'd0, 32'h0, 4'b0, 1'b1, 4'd2);
        tick();
        check("resweep_q_a",      bus_a.q,            CV);
        check("resweep_qvalid_a", 32'(bus_a.q_valid), 32'd1);
        drive_ab(1'b0, 4'd0, 32'h0, 4'b0, 1'b0, 4'd0);
        tick();
        check("resweep_q_b",      bus_b.q,            CV);
        check("resweep_qvalid_b", 32'(bus_b.q_valid), 32'd1);

        // No-clear instance: usable straight away, latency 2.
        drive_c(1'b1, 4'd9, 32'hCAFEF00D, 4'b1111, 1'b0, 4'd0);
        tick();
        check("noclr_busy_c", 32'(bus_c.busy), 32'd0);
        drive_c(1'b0, 4'd0, 32'h0, 4'b0, 1'b1, 4'd9);
        tick();
        check("noclr_lat1_qvalid_c", 32'(bus_c.q_valid), 32'd0);
        drive_c(1'b0, 4'd0, 32'h0, 4'b0, 1'b0, 4'd0);
        tick();
        check("noclr_qvalid_c", 32'(bus_c.q_valid), 32'd1);
        check("noclr_q_c",      bus_c.q,            32'hCAFEF00D);
        tick();
        check("noclr_drop_qvalid_c", 32'(bus_c.q_valid), 32'd0);
        check("noclr_hold_q_c",      bus_c.q,            32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
